// File: rtl/grant_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : grant_sched_pkg
// Purpose : Shared types and constants for the grant scheduler.
//           - state_t  : scheduler FSM states (IDLE / GRANT / GAP)
//           - N        : number of requesters
//           - HOLD_MAX : maximum grant tenure in cycles
//           - IDX_W    : width of a requester index
//           - CNT_W    : width of the tenure counter
// Revision: 1.0 - initial release
// ============================================================================
package grant_sched_pkg;

  localparam int N        = 8;
  localparam int HOLD_MAX = 16;
  localparam int IDX_W    = 3;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage : grant_sched_pkg
`default_nettype wire

// File: rtl/grant_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational winner selection for the grant scheduler.
// Ports   : req       in  [N-1:0]     request vector
//           start_idx in  [IDX_W-1:0] first index searched in round-robin mode
//           mode      in  1           0 = highest index wins, 1 = round-robin
//           idx       out [IDX_W-1:0] winning index (0 when nothing requested)
//           found     out 1           at least one request is set
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
  import grant_sched_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             mode,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    idx   = '0;
    found = |req;
    w_pos = '0;
    if (!mode) begin
      // Ascending scan: the last hit, i.e. the highest set index, sticks.
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end else begin
      // Descending offset scan so the smallest offset from start_idx sticks.
      // The index adder wraps modulo N because N == 2**IDX_W.
      for (int k = N - 1; k >= 0; k--) begin
        w_pos = start_idx + IDX_W'(k);
        if (req[w_pos]) idx = w_pos;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : grant_scheduler
// Purpose : Single-owner grant arbiter with fixed-priority / round-robin
//           selection, tenure limit and a mandatory release gap.
// Ports   : clk       in  1        rising-edge clock
//           rst       in  1        asynchronous active-high reset
//           req       in  [N-1:0]  request levels, bit i = requester i
//           done      in  1        owner release strobe
//           mode      in  1        0 = fixed priority, 1 = round-robin
//           gnt       out [N-1:0]  registered one-hot grant
//           gnt_idx   out [2:0]    current / last owner index
//           gnt_valid out 1        a grant is active
//           timeout   out 1        pulse in GAP after a tenure-limit revoke
// Revision: 1.0 - initial release
// ============================================================================
module grant_scheduler #(
  parameter int N        = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  input  logic                 mode,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic                 timeout
);

  import grant_sched_pkg::*;

  localparam logic [CNT_W-1:0] c_HOLD_LIM = CNT_W'(HOLD_MAX - 1);

  state_t           r_state,   w_state_nxt;
  logic [N-1:0]     r_gnt,     w_gnt_nxt;
  logic [IDX_W-1:0] r_idx,     w_idx_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic             r_valid,   w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic [IDX_W-1:0] w_pick_idx;
  logic             w_found;

  // Round-robin search begins one past the previous owner (wraps 7 -> 0).
  rr_pick u_rr_pick (
    .req       (req),
    .start_idx (r_idx + IDX_W'(1)),
    .mode      (mode),
    .idx       (w_pick_idx),
    .found     (w_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_idx     <= IDX_W'(N - 1);
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = N'(1) << w_pick_idx;
          w_idx_nxt   = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end

      GRANT: begin
        // Exit causes are prioritised so a release by the owner on the
        // limit cycle is not reported as a timeout.
        if (done || !req[r_idx]) begin
          w_state_nxt = GAP;
          w_gnt_nxt   = '0;
        end else if (r_cnt == c_HOLD_LIM) begin
          w_state_nxt   = GAP;
          w_gnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      GAP: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end

      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase

    w_valid_nxt = |w_gnt_nxt;
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign timeout   = r_timeout;

endmodule : grant_scheduler
`default_nettype wire
